aurora_frame_inserter: RTL and testbench

Framing stage between the 1024→64-bit width converter and the Aurora 64B/66B TX user interface, in the `user_clk_i` domain. It cuts the continuous 64-bit capture stream into sensor frames of fixed length. Each frame gets a header word (magic, length, frame number) in front and a trailer word (magic, length, XOR checksum) behind, so the host can resynchronise. While the Aurora channel is down, whole frames are drained and counted, so capture back-pressure never stalls the sensor path.

---
 rtl/spikep_link_pkg.sv | 28 ++
 rtl/aurora_frame_inserter.sv | 127 ++++++++++++
 tb/tb_aurora_frame_inserter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spikep_link_pkg.sv
// rtl/spikep_link_pkg.sv - shared framing constants, FSM state type and header/trailer packing
package spikep_link_pkg;

    localparam logic [15:0] HDR_MAGIC = 16'hA5C3;
    localparam logic [15:0] TRL_MAGIC = 16'h5A3C;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_TRAILER,
        ST_DROP
    } frame_state_t;

    function automatic logic [63:0] pack_header(input logic [15:0] len, input logic [31:0] frame_num);
        return {HDR_MAGIC, len, frame_num};
    endfunction

    function automatic logic [63:0] pack_trailer(input logic [15:0] len, input logic [31:0] csum);
        return {TRL_MAGIC, len, csum};
    endfunction

    // Folds one payload beat into the 32-bit running checksum term.
    function automatic logic [31:0] fold_beat(input logic [63:0] data);
        return data[63:32] ^ data[31:0];
    endfunction

endpackage

// File: rtl/aurora_frame_inserter.sv
// rtl/aurora_frame_inserter.sv - cuts the capture stream into framed sensor frames for Aurora TX
module aurora_frame_inserter
    import spikep_link_pkg::*;
#(
    parameter int WORDS_PER_FRAME = 2000
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        channel_up,
    input  logic [63:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [63:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [31:0] frame_count,
    output logic [15:0] drop_count
);

    localparam int               CNT_W     = $clog2(WORDS_PER_FRAME);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WORDS_PER_FRAME - 1);
    localparam logic [15:0]      FRAME_LEN = 16'(WORDS_PER_FRAME);

    frame_state_t     state;
    frame_state_t     state_next;
    logic [CNT_W-1:0] beat_cnt;
    logic [31:0]      checksum;
    logic             last_beat;
    logic             payload_hs;
    logic             drop_hs;

    assign last_beat  = (beat_cnt == LAST_BEAT);
    assign payload_hs = (state == ST_PAYLOAD) && s_axis_tvalid && m_axis_tready;
    assign drop_hs    = (state == ST_DROP) && s_axis_tvalid;

    always_comb begin
        state_next    = state;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        case (state)
            ST_IDLE: begin
                if (s_axis_tvalid) begin
                    state_next = channel_up ? ST_HEADER : ST_DROP;
                end
            end
            ST_HEADER: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = pack_header(FRAME_LEN, frame_count);
                if (m_axis_tready) begin
                    state_next = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                m_axis_tvalid = s_axis_tvalid;
                s_axis_tready = m_axis_tready;
                m_axis_tdata  = s_axis_tdata;
                if (payload_hs && last_beat) begin
                    state_next = ST_TRAILER;
                end
            end
            ST_TRAILER: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = pack_trailer(FRAME_LEN, checksum);
                if (m_axis_tready) begin
                    state_next = ST_IDLE;
                end
            end
            ST_DROP: begin
                // Drain at full rate so the width converter never sees back-pressure.
                s_axis_tready = 1'b1;
                if (drop_hs && last_beat) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= ST_IDLE;
            beat_cnt    <= '0;
            checksum    <= '0;
            frame_count <= '0;
            drop_count  <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    beat_cnt <= '0;
                end
                ST_HEADER: begin
                    if (m_axis_tready) begin
                        beat_cnt <= '0;
                        checksum <= '0;
                    end
                end
                ST_PAYLOAD: begin
                    if (payload_hs) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        checksum <= checksum ^ fold_beat(s_axis_tdata);
                    end
                end
                ST_TRAILER: begin
                    if (m_axis_tready) begin
                        frame_count <= frame_count + 32'd1;
                    end
                end
                ST_DROP: begin
                    if (drop_hs) begin
                        if (last_beat) begin
                            beat_cnt <= '0;
                            if (drop_count != 16'hFFFF) begin
                                drop_count <= drop_count + 16'd1;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                default: beat_cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_aurora_frame_inserter.sv
// tb/tb_aurora_frame_inserter.sv - scoreboard bench for aurora_frame_inserter with 4-beat frames
module tb_aurora_frame_inserter;

    logic        aclk          = 1'b0;
    logic        aresetn       = 1'b0;
    logic        channel_up    = 1'b0;
    logic [63:0] s_axis_tdata  = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic [31:0] frame_count;
    logic [15:0] drop_count;

    int          n_cmp     = 0;
    int          n_bad     = 0;
    int          tx_beats  = 0;
    logic [63:0] exp_q[$];
    logic        bp_en     = 1'b0;
    logic        rdy_force = 1'b1;

    aurora_frame_inserter #(.WORDS_PER_FRAME(4)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .channel_up    (channel_up),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .frame_count   (frame_count),
        .drop_count    (drop_count)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        #1;
        m_axis_tready = bp_en ? 1'($urandom_range(0, 1)) : rdy_force;
    end

    always @(negedge aclk) begin
        logic [63:0] exp_word;
        if (aresetn && m_axis_tvalid) tx_beats++;
        if (aresetn && m_axis_tvalid && m_axis_tready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL out_word: got %h, nothing expected", m_axis_tdata);
            end else begin
                exp_word = exp_q.pop_front();
                if (m_axis_tdata !== exp_word) begin
                    n_bad++;
                    $display("FAIL out_word: got %h, expected %h", m_axis_tdata, exp_word);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send_beat(input logic [63:0] d);
        int t = 0;
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        do begin
            @(negedge aclk);
            t++;
        end while (!s_axis_tready && t < 200);
        if (!s_axis_tready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL src_timeout: beat %h not accepted, expected accept within 200 cycles", d);
        end
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic push_frame(input logic [63:0] w[4], input logic [31:0] fn, input logic [31:0] csum);
        exp_q.push_back({16'hA5C3, 16'h0004, fn});
        for (int i = 0; i < 4; i++) exp_q.push_back(w[i]);
        exp_q.push_back({16'h5A3C, 16'h0004, csum});
    endtask

    task automatic send_frame(input logic [63:0] w[4], input logic [31:0] fn, input logic [31:0] csum);
        push_frame(w, fn, csum);
        for (int i = 0; i < 4; i++) send_beat(w[i]);
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge aclk);
            #1;
            t++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        aresetn       = 1'b0;
        s_axis_tvalid = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    initial begin
        logic [63:0] w_inc[4];
        logic [63:0] w_mid[4];
        logic [63:0] w_sum[4];
        int          tx0;
        w_inc = '{64'd1, 64'd2, 64'd3, 64'd4};
        w_mid = '{64'd10, 64'd20, 64'd30, 64'd40};
        w_sum = '{64'hFFFFFFFF_00000000, 64'hFFFFFFFF_00000000, 64'hFFFFFFFF_00000000, 64'h0};

        channel_up = 1'b1;
        #12;
        check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_s_tready", 64'(s_axis_tready), 64'd0);
        check("rst_m_tdata", m_axis_tdata, 64'd0);
        check("rst_frame_count", 64'(frame_count), 64'd0);
        check("rst_drop_count", 64'(drop_count), 64'd0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;

        // Basic frame with literal expected words.
        exp_q.push_back(64'hA5C3_0004_0000_0000);
        exp_q.push_back(64'd1);
        exp_q.push_back(64'd2);
        exp_q.push_back(64'd3);
        exp_q.push_back(64'd4);
        exp_q.push_back(64'h5A3C_0004_0000_0004);
        for (int i = 0; i < 4; i++) send_beat(w_inc[i]);
        wait_drain("basic_drain");
        check("basic_frame_count", 64'(frame_count), 64'd1);

        // Random sink back-pressure over three frames.
        do_reset();
        bp_en = 1'b1;
        for (int f = 0; f < 3; f++) send_frame(w_inc, 32'(f), 32'd4);
        wait_drain("bp_drain");
        bp_en = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        check("bp_frame_count", 64'(frame_count), 64'd3);

        // Link down: two frames drained, nothing transmitted.
        do_reset();
        channel_up = 1'b0;
        tx0 = tx_beats;
        for (int f = 0; f < 2; f++) begin
            send_beat(w_inc[0]);
            check("drop_s_tready", 64'(s_axis_tready), 64'd1);
            for (int i = 1; i < 4; i++) send_beat(w_inc[i]);
        end
        repeat (3) @(posedge aclk);
        #1;
        check("drop_drop_count", 64'(drop_count), 64'd2);
        check("drop_frame_count", 64'(frame_count), 64'd0);
        check("drop_no_tvalid", 64'(tx_beats - tx0), 64'd0);
        channel_up = 1'b1;
        send_frame(w_inc, 32'd0, 32'd4);
        wait_drain("relink_drain");
        check("relink_frame_count", 64'(frame_count), 64'd1);

        // Link drops at payload beat 2; Aurora stalls the sink until it returns.
        push_frame(w_mid, 32'd1, 32'h28);
        send_beat(w_mid[0]);
        send_beat(w_mid[1]);
        channel_up = 1'b0;
        rdy_force  = 1'b0;
        repeat (2) @(posedge aclk);
        #2;
        s_axis_tdata  = w_mid[2];
        s_axis_tvalid = 1'b1;
        repeat (4) @(negedge aclk);
        check("stall_m_tvalid", 64'(m_axis_tvalid), 64'd1);
        check("stall_s_tready", 64'(s_axis_tready), 64'd0);
        channel_up = 1'b1;
        rdy_force  = 1'b1;
        send_beat(w_mid[2]);
        send_beat(w_mid[3]);
        wait_drain("middrop_drain");
        check("middrop_drop_count", 64'(drop_count), 64'd2);
        check("middrop_frame_count", 64'(frame_count), 64'd2);

        // Checksum: three 0xFFFFFFFF terms and a zero beat leave 0xFFFFFFFF.
        send_frame(w_sum, 32'd2, 32'hFFFFFFFF);
        wait_drain("csum_drain");
        check("csum_frame_count", 64'(frame_count), 64'd3);

        // Reset asserted while payload beat 2 is presented.
        exp_q.push_back({16'hA5C3, 16'h0004, 32'd3});
        exp_q.push_back(64'd5);
        exp_q.push_back(64'd6);
        send_beat(64'd5);
        send_beat(64'd6);
        s_axis_tdata  = 64'd7;
        s_axis_tvalid = 1'b1;
        #1;
        aresetn = 1'b0;
        #1;
        check("midrst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("midrst_s_tready", 64'(s_axis_tready), 64'd0);
        check("midrst_m_tdata", m_axis_tdata, 64'd0);
        check("midrst_frame_count", 64'(frame_count), 64'd0);
        check("midrst_pre_words", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        s_axis_tvalid = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        send_frame(w_inc, 32'd0, 32'd4);
        wait_drain("postrst_drain");
        check("postrst_frame_count", 64'(frame_count), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at 500000, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
